// File: rtl/rs_station.sv
// Reservation station: holds dispatched instructions, captures operands from
// the CDB by ROB tag and issues the oldest fully ready entry to one FU.
module rs_station #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OP_W   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         disp_valid,
  output logic                         disp_ready,
  input  logic [OP_W-1:0]              disp_op,
  input  logic [TAG_W-1:0]             disp_dest,
  input  logic                         disp_s1_rdy,
  input  logic [DATA_W-1:0]            disp_s1_val,
  input  logic [TAG_W-1:0]             disp_s1_tag,
  input  logic                         disp_s2_rdy,
  input  logic [DATA_W-1:0]            disp_s2_val,
  input  logic [TAG_W-1:0]             disp_s2_tag,
  input  logic                         cdb_valid,
  input  logic [TAG_W-1:0]             cdb_tag,
  input  logic [DATA_W-1:0]            cdb_data,
  output logic                         issue_valid,
  input  logic                         issue_ready,
  output logic [OP_W-1:0]              issue_op,
  output logic [TAG_W-1:0]             issue_dest,
  output logic [DATA_W-1:0]            issue_s1,
  output logic [DATA_W-1:0]            issue_s2,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]  busy, s1_rdy, s2_rdy;
  logic [OP_W-1:0]   op_q   [DEPTH];
  logic [TAG_W-1:0]  dest_q [DEPTH];
  logic [TAG_W-1:0]  s1_tag [DEPTH];
  logic [TAG_W-1:0]  s2_tag [DEPTH];
  logic [DATA_W-1:0] s1_val [DEPTH];
  logic [DATA_W-1:0] s2_val [DEPTH];
  // age[i][j] set means entry i is older than entry j
  logic [DEPTH-1:0]  age    [DEPTH];

  logic              lock;
  logic [IW-1:0]     lock_idx;

  logic [DEPTH-1:0]  cand;
  logic              pick_any, oldest;
  logic [IW-1:0]     pick_idx, sel_idx, free_idx;
  logic              disp_fire, issue_fire, byp1, byp2;

  assign disp_ready = (count < CW'(DEPTH));
  assign disp_fire  = disp_valid & disp_ready;
  assign issue_fire = issue_valid & issue_ready;
  assign cand       = busy & s1_rdy & s2_rdy;
  assign byp1       = cdb_valid & ~disp_s1_rdy & (disp_s1_tag == cdb_tag);
  assign byp2       = cdb_valid & ~disp_s2_rdy & (disp_s2_tag == cdb_tag);

  // Lowest-index free entry
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy[i]) free_idx = IW'(i);
    end
  end

  // Oldest candidate: older than every other candidate
  always_comb begin
    pick_any = 1'b0;
    pick_idx = '0;
    oldest   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      oldest = cand[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && cand[j] && !age[i][j]) oldest = 1'b0;
      end
      if (oldest) begin
        pick_any = 1'b1;
        pick_idx = IW'(i);
      end
    end
  end

  // A stalled issue stays locked to its entry so the FU sees stable outputs
  assign sel_idx     = lock ? lock_idx : pick_idx;
  assign issue_valid = lock | pick_any;
  assign issue_op    = issue_valid ? op_q[sel_idx]   : '0;
  assign issue_dest  = issue_valid ? dest_q[sel_idx] : '0;
  assign issue_s1    = issue_valid ? s1_val[sel_idx] : '0;
  assign issue_s2    = issue_valid ? s2_val[sel_idx] : '0;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      busy     <= '0;
      lock     <= 1'b0;
      lock_idx <= '0;
      count    <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (cdb_valid && busy[i]) begin
          if (!s1_rdy[i] && s1_tag[i] == cdb_tag) begin
            s1_rdy[i] <= 1'b1;
            s1_val[i] <= cdb_data;
          end
          if (!s2_rdy[i] && s2_tag[i] == cdb_tag) begin
            s2_rdy[i] <= 1'b1;
            s2_val[i] <= cdb_data;
          end
        end
      end

      if (issue_fire) begin
        busy[sel_idx] <= 1'b0;
        lock          <= 1'b0;
      end else if (issue_valid) begin
        lock     <= 1'b1;
        lock_idx <= sel_idx;
      end

      // New entry becomes younger than everything already present
      if (disp_fire) begin
        busy[free_idx]   <= 1'b1;
        op_q[free_idx]   <= disp_op;
        dest_q[free_idx] <= disp_dest;
        s1_tag[free_idx] <= disp_s1_tag;
        s2_tag[free_idx] <= disp_s2_tag;
        s1_rdy[free_idx] <= disp_s1_rdy | byp1;
        s2_rdy[free_idx] <= disp_s2_rdy | byp2;
        s1_val[free_idx] <= disp_s1_rdy ? disp_s1_val : cdb_data;
        s2_val[free_idx] <= disp_s2_rdy ? disp_s2_val : cdb_data;
        age[free_idx]    <= '0;
        for (int j = 0; j < DEPTH; j++) begin
          if (IW'(j) != free_idx) age[j][free_idx] <= 1'b1;
        end
      end

      count <= count + CW'(disp_fire) - CW'(issue_fire);
    end
  end

endmodule

// File: tb/tb_rs_station.sv
// Directed bench for rs_station: dispatch, wakeup, bypass, full, hold, flush.
module tb_rs_station;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        disp_valid, disp_ready;
  logic [3:0]  disp_op, disp_dest;
  logic        disp_s1_rdy, disp_s2_rdy;
  logic [31:0] disp_s1_val, disp_s2_val;
  logic [3:0]  disp_s1_tag, disp_s2_tag;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        issue_valid, issue_ready;
  logic [3:0]  issue_op, issue_dest;
  logic [31:0] issue_s1, issue_s2;
  logic [3:0]  count;

  int tests = 0;
  int fails = 0;

  rs_station #(.DEPTH(8), .TAG_W(4), .DATA_W(32), .OP_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_op(disp_op), .disp_dest(disp_dest),
    .disp_s1_rdy(disp_s1_rdy), .disp_s1_val(disp_s1_val), .disp_s1_tag(disp_s1_tag),
    .disp_s2_rdy(disp_s2_rdy), .disp_s2_val(disp_s2_val), .disp_s2_tag(disp_s2_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_op(issue_op), .issue_dest(issue_dest),
    .issue_s1(issue_s1), .issue_s2(issue_s2),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs are changed 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_disp(input logic v, input logic [3:0] op, input logic [3:0] dest,
                          input logic r1, input logic [31:0] v1, input logic [3:0] t1,
                          input logic r2, input logic [31:0] v2, input logic [3:0] t2);
    disp_valid = v; disp_op = op; disp_dest = dest;
    disp_s1_rdy = r1; disp_s1_val = v1; disp_s1_tag = t1;
    disp_s2_rdy = r2; disp_s2_val = v2; disp_s2_tag = t2;
  endtask

  task automatic set_cdb(input logic v, input logic [3:0] t, input logic [31:0] d);
    cdb_valid = v; cdb_tag = t; cdb_data = d;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; issue_ready = 1'b0;
    set_disp(1'b0, 4'd0, 4'd0, 1'b0, 32'h0, 4'd0, 1'b0, 32'h0, 4'd0);
    set_cdb(1'b0, 4'd0, 32'h0);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_disp_ready", 32'(disp_ready), 32'd1);
    chk("rst_issue_valid", 32'(issue_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_issue_s1", issue_s1, 32'h0);
    chk("rst_issue_dest", 32'(issue_dest), 32'd0);

    // Basic ready dispatch then issue
    set_disp(1'b1, 4'd3, 4'd5, 1'b1, 32'h10, 4'd0, 1'b1, 32'h20, 4'd0);
    tick();
    set_disp(1'b0, 4'd0, 4'd0, 1'b0, 32'h0, 4'd0, 1'b0, 32'h0, 4'd0);
    chk("basic_valid", 32'(issue_valid), 32'd1);
    chk("basic_op", 32'(issue_op), 32'd3);
    chk("basic_dest", 32'(issue_dest), 32'd5);
    chk("basic_s1", issue_s1, 32'h10);
    chk("basic_s2", issue_s2, 32'h20);
    chk("basic_count1", 32'(count), 32'd1);
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    chk("basic_count0", 32'(count), 32'd0);
    chk("basic_drained", 32'(issue_valid), 32'd0);

    // Wait on tag 7, broadcast two cycles later
    set_disp(1'b1, 4'd1, 4'd2, 1'b0, 32'h0, 4'd7, 1'b1, 32'h33, 4'd0);
    tick();
    set_disp(1'b0, 4'd0, 4'd0, 1'b0, 32'h0, 4'd0, 1'b0, 32'h0, 4'd0);
    chk("wake_wait", 32'(issue_valid), 32'd0);
    chk("wake_count", 32'(count), 32'd1);
    tick();
    set_cdb(1'b1, 4'd7, 32'hAB);
    #1;
    chk("wake_no_same_cycle", 32'(issue_valid), 32'd0);
    tick();
    set_cdb(1'b0, 4'd0, 32'h0);
    chk("wake_valid", 32'(issue_valid), 32'd1);
    chk("wake_dest", 32'(issue_dest), 32'd2);
    chk("wake_s1", issue_s1, 32'hAB);
    chk("wake_s2", issue_s2, 32'h33);
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;

    // Dispatch-time bypass on both sources
    set_disp(1'b1, 4'd2, 4'd4, 1'b0, 32'h0, 4'd9, 1'b0, 32'h0, 4'd9);
    set_cdb(1'b1, 4'd9, 32'h55);
    tick();
    set_disp(1'b0, 4'd0, 4'd0, 1'b0, 32'h0, 4'd0, 1'b0, 32'h0, 4'd0);
    set_cdb(1'b0, 4'd0, 32'h0);
    chk("byp_valid", 32'(issue_valid), 32'd1);
    chk("byp_s1", issue_s1, 32'h55);
    chk("byp_s2", issue_s2, 32'h55);
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    chk("byp_count", 32'(count), 32'd0);

    // Fill all 8 entries with dests 8..15 while the FU stalls
    for (int i = 0; i < 8; i++) begin
      set_disp(1'b1, 4'd1, 4'(8 + i), 1'b1, 32'(i), 4'd0, 1'b1, 32'h0, 4'd0);
      tick();
    end
    set_disp(1'b1, 4'd1, 4'd3, 1'b1, 32'h0, 4'd0, 1'b1, 32'h0, 4'd0);
    #1;
    chk("full_count", 32'(count), 32'd8);
    chk("full_ready", 32'(disp_ready), 32'd0);
    chk("full_oldest", 32'(issue_dest), 32'd8);
    tick();
    set_disp(1'b0, 4'd0, 4'd0, 1'b0, 32'h0, 4'd0, 1'b0, 32'h0, 4'd0);
    chk("full_ignored", 32'(count), 32'd8);
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    chk("full_count7", 32'(count), 32'd7);
    chk("full_ready_again", 32'(disp_ready), 32'd1);
    // Entry 0 is reused but must be youngest
    set_disp(1'b1, 4'd1, 4'd1, 1'b1, 32'h0, 4'd0, 1'b1, 32'h0, 4'd0);
    tick();
    set_disp(1'b0, 4'd0, 4'd0, 1'b0, 32'h0, 4'd0, 1'b0, 32'h0, 4'd0);
    chk("refill_count", 32'(count), 32'd8);
    issue_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("drain_dest%0d", k), 32'(issue_dest), (k < 7) ? 32'(9 + k) : 32'd1);
      tick();
    end
    issue_ready = 1'b0;
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_valid", 32'(issue_valid), 32'd0);

    // Issue hold: B presented, A wakes, B must stay until accepted
    set_disp(1'b1, 4'd5, 4'd6, 1'b0, 32'h0, 4'd12, 1'b1, 32'h66, 4'd0);
    tick();
    set_disp(1'b1, 4'd6, 4'd7, 1'b1, 32'h71, 4'd0, 1'b1, 32'h72, 4'd0);
    tick();
    set_disp(1'b0, 4'd0, 4'd0, 1'b0, 32'h0, 4'd0, 1'b0, 32'h0, 4'd0);
    chk("hold_b_dest", 32'(issue_dest), 32'd7);
    set_cdb(1'b1, 4'd12, 32'h77);
    tick();
    set_cdb(1'b0, 4'd0, 32'h0);
    tick();
    chk("hold_still_b", 32'(issue_dest), 32'd7);
    chk("hold_still_b_s1", issue_s1, 32'h71);
    chk("hold_still_b_op", 32'(issue_op), 32'd6);
    issue_ready = 1'b1;
    tick();
    chk("hold_a_dest", 32'(issue_dest), 32'd6);
    chk("hold_a_s1", issue_s1, 32'h77);
    chk("hold_a_s2", issue_s2, 32'h66);
    tick();
    issue_ready = 1'b0;
    chk("hold_count", 32'(count), 32'd0);

    // Flush with 5 entries and a simultaneous dispatch
    for (int i = 0; i < 5; i++) begin
      set_disp(1'b1, 4'd2, 4'(i), (i % 2) == 0, 32'h1, 4'd13, 1'b1, 32'h2, 4'd0);
      tick();
    end
    set_disp(1'b0, 4'd0, 4'd0, 1'b0, 32'h0, 4'd0, 1'b0, 32'h0, 4'd0);
    chk("preflush_count", 32'(count), 32'd5);
    flush = 1'b1;
    issue_ready = 1'b1;
    set_disp(1'b1, 4'd3, 4'd14, 1'b1, 32'h0, 4'd0, 1'b1, 32'h0, 4'd0);
    tick();
    flush = 1'b0;
    issue_ready = 1'b0;
    set_disp(1'b0, 4'd0, 4'd0, 1'b0, 32'h0, 4'd0, 1'b0, 32'h0, 4'd0);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid", 32'(issue_valid), 32'd0);
    chk("flush_disp_ready", 32'(disp_ready), 32'd1);
    set_cdb(1'b1, 4'd13, 32'h99);
    tick();
    set_cdb(1'b0, 4'd0, 32'h0);
    tick();
    chk("flush_no_ghost", 32'(issue_valid), 32'd0);
    chk("flush_count_after", 32'(count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rs_station.md
# rs_station

Parametrised reservation station for the out-of-order MIPS pipeline, sitting between dispatch (rename/ROB allocate) and one functional unit. It holds up to DEPTH in-flight instructions, captures missing source operands from the common data bus (CDB) by ROB tag, and issues the oldest fully ready entry through a valid/ready handshake. It adds parametrised depth and widths, same-cycle CDB bypass at dispatch, age-ordered issue, issue-hold stability, flush and an occupancy count.

## Interface
- DEPTH, 8, number of entries (power of two, >= 2)
- TAG_W, 4, ROB tag width
- DATA_W, 32, operand width
- OP_W, 4, FU opcode width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all entries (mispredict recovery)
- disp_valid  in  1  dispatch request
- disp_ready  out  1  an entry is free (count < DEPTH)
- disp_op  in  OP_W  opcode
- disp_dest  in  TAG_W  ROB tag of the result
- disp_s1_rdy / disp_s2_rdy  in  1  source value present
- disp_s1_val / disp_s2_val  in  DATA_W  source value (valid when rdy)
- disp_s1_tag / disp_s2_tag  in  TAG_W  producer tag (used when not rdy)
- cdb_valid  in  1  broadcast valid
- cdb_tag  in  TAG_W  broadcast producer tag
- cdb_data  in  DATA_W  broadcast value
- issue_valid  out  1  a ready entry is presented
- issue_ready  in  1  FU accepts
- issue_op  out  OP_W;  issue_dest  out  TAG_W;  issue_s1 / issue_s2  out  DATA_W
- count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Entry state: busy, op, dest, per source {rdy, tag, val}; age matrix DEPTH x DEPTH (row i bit j = entry i older than j).
- Dispatch: disp_valid & disp_ready writes the lowest-index free entry; new entry marked younger than all busy entries.
- Dispatch bypass: source with rdy=0 whose tag equals cdb_tag while cdb_valid is written as rdy=1, val=cdb_data.
- Wakeup: every busy entry with a non-ready source whose tag matches cdb_tag (cdb_valid) sets rdy and latches cdb_data; both sources may match the same broadcast.
- Select: candidates = busy & s1.rdy & s2.rdy; pick the one older than all other candidates. issue_* driven combinationally from the chosen entry.
- Issue hold: when issue_valid & !issue_ready, the selected index is locked; outputs stay identical until accepted, even if an older entry becomes ready.
- Issue: issue_valid & issue_ready frees the entry at the edge; lock released.
- count next = count + dispatch_fire - issue_fire.
- flush / rst: all busy cleared, lock cleared, count 0; a same-cycle dispatch, wakeup or issue is discarded (issue_ready ignored).
- Reset values: disp_ready 1, issue_valid 0, count 0, issue_* data 0.

## Timing
- Dispatch at edge N with both sources ready (or bypassed): issue_valid earliest in cycle N+1.
- CDB wakeup at edge N: entry a candidate in cycle N+1; no same-cycle wakeup-to-issue.
- disp_ready reflects registered count only; an entry freed by issue in cycle N is reusable from cycle N+1. Full (count == DEPTH): disp_ready 0, disp_valid ignored.
- Simultaneous dispatch and issue in one cycle: count unchanged.
- CDB tag matching no waiting source: no state change.
- Index and count arithmetic wrap-free; count never exceeds DEPTH or goes below 0.

## Test plan
- Reset then dispatch op=3, dest=5, s1=0x10, s2=0x20 both ready -> next cycle issue_valid=1, issue_dest=5, issue_s1=0x10, issue_s2=0x20; issue_ready=1 -> count 1 to 0.
- Dispatch dest=2 with s1 waiting tag 7; CDB tag 7 data 0xAB two cycles later -> issue_valid one cycle after the broadcast with issue_s1=0xAB.
- Dispatch waiting on tag 9 in the same cycle as CDB tag 9 data 0x55 -> entry ready; issue next cycle with s=0x55.
- Fill 8 entries (DEPTH=8), hold issue_ready=0 -> disp_ready=0, count=8; extra disp_valid ignored; one issue accept -> disp_ready=1 next cycle.
- Dispatch A (waiting) then B (ready); B presented, issue_ready=0; wake A -> outputs stay B until accepted, then A issued.
- Mid-stream flush with 5 entries and a simultaneous dispatch -> count 0, issue_valid 0 next cycle, no entry from the dropped dispatch.
